// File: rtl/mem_responder_if.sv
// mem_responder_if
//   Bus bundle between the CPU controller / address mux (master) and the
//   memory responder (slave).
//   Signals:
//     addr     master->slave  byte address
//     rd, wr   master->slave  read / write strobes
//     data_in  master->slave  write data
//     data_out slave->master  read data
//     data_oe  slave->master  data_out drives the shared bus
//     rdy      slave->master  one-cycle transaction-complete pulse
//     busy     slave->master  transaction in progress
//     err      slave->master  sticky rd&&wr collision flag
interface mem_responder_if #(
    parameter int unsigned ADDR_W = 13,
    parameter int unsigned DATA_W = 8
);
    logic [ADDR_W-1:0] addr;
    logic              rd;
    logic              wr;
    logic [DATA_W-1:0] data_in;
    logic [DATA_W-1:0] data_out;
    logic              data_oe;
    logic              rdy;
    logic              busy;
    logic              err;

    modport master (
        output addr, rd, wr, data_in,
        input  data_out, data_oe, rdy, busy, err
    );

    modport slave (
        input  addr, rd, wr, data_in,
        output data_out, data_oe, rdy, busy, err
    );
endinterface

// File: rtl/mem_responder.sv
// mem_responder
//   Memory-side responder for the controller's rd/wr strobes. Each request
//   becomes a timed transaction on an internal byte RAM with WAIT_CYCLES
//   wait states; reads return data with an output enable, and every
//   completed transaction produces a one-cycle rdy pulse.
//   Ports:
//     clk    clock, all state updates on posedge
//     reset  asynchronous active-high reset (RAM contents are kept)
//     bus    mem_responder_if.slave: addr, rd, wr, data_in in;
//            data_out, data_oe, rdy, busy, err out (all registered)
module mem_responder #(
    parameter int unsigned ADDR_W      = 13,
    parameter int unsigned DATA_W      = 8,
    parameter int unsigned WAIT_CYCLES = 2
) (
    input logic            clk,
    input logic            reset,
    mem_responder_if.slave bus
);

    localparam int unsigned DEPTH   = 1 << ADDR_W;
    localparam logic [3:0]  WAIT_LD = 4'(WAIT_CYCLES);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP, S_HOLD} state_t;
    typedef enum logic {K_RD, K_WR} kind_t;

    state_t            state_q, state_d;
    kind_t             kind_q, kind_d;
    logic [3:0]        cnt_q, cnt_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [DATA_W-1:0] data_out_q, data_out_d;
    logic              oe_q, oe_d;
    logic              rdy_q, rdy_d;
    logic              busy_q, busy_d;
    logic              err_q, err_d;

    logic [DATA_W-1:0] mem [0:DEPTH-1];
    logic              mem_we;
    logic [ADDR_W-1:0] mem_waddr;
    logic [DATA_W-1:0] mem_wdata;

    logic  one_strobe;
    logic  kind_held;
    logic  accept;
    kind_t req_kind;

    always_comb begin
        state_d    = state_q;
        kind_d     = kind_q;
        cnt_d      = cnt_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        data_out_d = data_out_q;
        oe_d       = oe_q;
        mem_we     = 1'b0;
        mem_waddr  = addr_q;
        mem_wdata  = wdata_q;
        accept     = 1'b0;

        one_strobe = bus.rd ^ bus.wr;
        req_kind   = bus.wr ? K_WR : K_RD;
        kind_held  = (kind_q == K_WR) ? bus.wr : bus.rd;

        // rdy and busy reflect the state one cycle late, so rdy appears
        // the cycle after RESP and busy covers the same window.
        rdy_d  = (state_q == S_RESP);
        busy_d = (state_q == S_WAIT) || (state_q == S_RESP);
        err_d  = err_q | (bus.rd & bus.wr);

        case (state_q)
            S_IDLE: begin
                if (one_strobe) accept = 1'b1;
            end
            S_WAIT: begin
                if (!kind_held) begin
                    // Strobe withdrawn: abandon without touching RAM.
                    state_d = S_IDLE;
                    oe_d    = 1'b0;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                    if (cnt_q == 4'd1) begin
                        state_d = S_RESP;
                        if (kind_q == K_WR) mem_we = 1'b1;
                    end
                end
            end
            S_RESP: begin
                state_d = S_HOLD;
                if (kind_q == K_RD) begin
                    oe_d       = 1'b1;
                    data_out_d = mem[addr_q];
                end else begin
                    oe_d = 1'b0;
                end
            end
            S_HOLD: begin
                if (!one_strobe) begin
                    state_d = S_IDLE;
                    oe_d    = 1'b0;
                end else if (req_kind != kind_q) begin
                    accept = 1'b1;
                    oe_d   = 1'b0;
                end else if (bus.addr != addr_q) begin
                    // Same strobe, new address: back-to-back fetch.
                    accept = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (accept) begin
            addr_d = bus.addr;
            kind_d = req_kind;
            if (req_kind == K_WR) begin
                wdata_d = bus.data_in;
                oe_d    = 1'b0;
            end
            if (WAIT_CYCLES == 0) begin
                // No wait states: the write commits on the accepting edge,
                // so it must use the live bus values, not the latches.
                state_d = S_RESP;
                if (req_kind == K_WR) begin
                    mem_we    = 1'b1;
                    mem_waddr = bus.addr;
                    mem_wdata = bus.data_in;
                end
            end else begin
                state_d = S_WAIT;
                cnt_d   = WAIT_LD;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= S_IDLE;
            kind_q     <= K_RD;
            cnt_q      <= '0;
            addr_q     <= '0;
            wdata_q    <= '0;
            data_out_q <= '0;
            oe_q       <= 1'b0;
            rdy_q      <= 1'b0;
            busy_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            kind_q     <= kind_d;
            cnt_q      <= cnt_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            data_out_q <= data_out_d;
            oe_q       <= oe_d;
            rdy_q      <= rdy_d;
            busy_q     <= busy_d;
            err_q      <= err_d;
        end
    end

    always_ff @(posedge clk) begin
        if (mem_we) mem[mem_waddr] <= mem_wdata;
    end

    assign bus.data_out = data_out_q;
    assign bus.data_oe  = oe_q;
    assign bus.rdy      = rdy_q;
    assign bus.busy     = busy_q;
    assign bus.err      = err_q;

endmodule

// File: tb/tb_mem_responder.sv
// tb_mem_responder
//   Directed bench for mem_responder: three instances with 2, 0 and 3 wait
//   states share clock and reset; each scenario drives one of them.
module tb_mem_responder;

    logic clk   = 1'b0;
    logic reset = 1'b0;
    int   ntests = 0;
    int   nfail  = 0;

    always #5 clk = ~clk;

    mem_responder_if #(.ADDR_W(13), .DATA_W(8)) if2 ();
    mem_responder_if #(.ADDR_W(13), .DATA_W(8)) if0 ();
    mem_responder_if #(.ADDR_W(13), .DATA_W(8)) if3 ();

    mem_responder #(.ADDR_W(13), .DATA_W(8), .WAIT_CYCLES(2)) u2 (
        .clk(clk), .reset(reset), .bus(if2)
    );
    mem_responder #(.ADDR_W(13), .DATA_W(8), .WAIT_CYCLES(0)) u0 (
        .clk(clk), .reset(reset), .bus(if0)
    );
    mem_responder #(.ADDR_W(13), .DATA_W(8), .WAIT_CYCLES(3)) u3 (
        .clk(clk), .reset(reset), .bus(if3)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        ntests++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic chk8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        ntests++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "bench timeout");
    end

    initial begin
        if2.rd = 1'b0; if2.wr = 1'b0; if2.addr = '0; if2.data_in = '0;
        if0.rd = 1'b0; if0.wr = 1'b0; if0.addr = '0; if0.data_in = '0;
        if3.rd = 1'b0; if3.wr = 1'b0; if3.addr = '0; if3.data_in = '0;

        // Reset state
        reset = 1'b1;
        #1;
        chk1("rst_rdy",  if2.rdy,     1'b0);
        chk1("rst_busy", if2.busy,    1'b0);
        chk1("rst_oe",   if2.data_oe, 1'b0);
        chk1("rst_err",  if2.err,     1'b0);
        chk8("rst_dout", if2.data_out, 8'h00);
        step(); step();
        reset = 1'b0;
        step();

        // 1. W=2 write 0xA5 to 0x0010
        if2.wr = 1'b1; if2.addr = 13'h0010; if2.data_in = 8'hA5;
        step();
        chk1("t1_e0_rdy", if2.rdy, 1'b0);
        chk1("t1_e0_oe",  if2.data_oe, 1'b0);
        step();
        chk1("t1_e1_busy", if2.busy, 1'b1);
        chk1("t1_e1_rdy",  if2.rdy,  1'b0);
        step();
        chk1("t1_e2_rdy", if2.rdy, 1'b0);
        step();
        chk1("t1_e3_rdy", if2.rdy, 1'b1);
        chk1("t1_e3_oe",  if2.data_oe, 1'b0);
        if2.wr = 1'b0;
        step();
        chk1("t1_e4_rdy", if2.rdy, 1'b0);
        chk1("t1_e4_oe",  if2.data_oe, 1'b0);
        step();

        // 2. W=2 read back 0x0010
        if2.rd = 1'b1; if2.addr = 13'h0010;
        step();
        step();
        chk1("t2_e1_busy", if2.busy, 1'b1);
        chk1("t2_e1_rdy",  if2.rdy,  1'b0);
        step();
        chk1("t2_e2_rdy", if2.rdy, 1'b0);
        chk1("t2_e2_oe",  if2.data_oe, 1'b0);
        step();
        chk1("t2_e3_rdy", if2.rdy, 1'b1);
        chk1("t2_e3_oe",  if2.data_oe, 1'b1);
        chk8("t2_e3_dout", if2.data_out, 8'hA5);
        step();
        chk1("t2_e4_rdy", if2.rdy, 1'b0);
        chk1("t2_e4_oe",  if2.data_oe, 1'b1);
        chk8("t2_e4_dout", if2.data_out, 8'hA5);
        if2.rd = 1'b0;
        step();
        chk1("t2_e5_oe",   if2.data_oe, 1'b0);
        chk1("t2_e5_busy", if2.busy, 1'b0);
        step();

        // 3. W=0: preload 0x10/0x11, then back-to-back read with rd held
        if0.wr = 1'b1; if0.addr = 13'h0010; if0.data_in = 8'hA5;
        step(); step();
        chk1("t3_w0_rdy", if0.rdy, 1'b1);
        if0.wr = 1'b0;
        step();
        if0.wr = 1'b1; if0.addr = 13'h0011; if0.data_in = 8'h3C;
        step(); step();
        chk1("t3_w1_rdy", if0.rdy, 1'b1);
        if0.wr = 1'b0;
        step();
        if0.rd = 1'b1; if0.addr = 13'h0010;
        step();
        chk1("t3_a_rdy", if0.rdy, 1'b0);
        step();
        chk1("t3_b_rdy", if0.rdy, 1'b1);
        chk1("t3_b_oe",  if0.data_oe, 1'b1);
        chk8("t3_b_dout", if0.data_out, 8'hA5);
        step();
        chk1("t3_c_rdy", if0.rdy, 1'b0);
        chk8("t3_c_dout", if0.data_out, 8'hA5);
        if0.addr = 13'h0011;
        step();
        chk1("t3_d_rdy", if0.rdy, 1'b0);
        chk1("t3_d_oe",  if0.data_oe, 1'b1);
        step();
        chk1("t3_e_rdy", if0.rdy, 1'b1);
        chk8("t3_e_dout", if0.data_out, 8'h3C);
        if0.rd = 1'b0;
        step();
        chk1("t3_f_oe", if0.data_oe, 1'b0);
        step();

        // 4. W=3: preload 0x20=0x11, then aborted write of 0x77
        if3.wr = 1'b1; if3.addr = 13'h0020; if3.data_in = 8'h11;
        step(); step(); step(); step();
        chk1("t4_pre_e3_rdy", if3.rdy, 1'b0);
        step();
        chk1("t4_pre_e4_rdy", if3.rdy, 1'b1);
        if3.wr = 1'b0;
        step();
        if3.wr = 1'b1; if3.data_in = 8'h77;
        step(); step();
        if3.wr = 1'b0;
        step();
        chk1("t4_ab_e2_rdy", if3.rdy, 1'b0);
        step();
        chk1("t4_ab_e3_rdy",  if3.rdy,  1'b0);
        chk1("t4_ab_e3_busy", if3.busy, 1'b0);
        step();
        chk1("t4_ab_e4_rdy", if3.rdy, 1'b0);
        step();
        chk1("t4_ab_e5_rdy", if3.rdy, 1'b0);
        if3.rd = 1'b1;
        step(); step(); step(); step(); step();
        chk1("t4_rd_rdy", if3.rdy, 1'b1);
        chk8("t4_rd_dout", if3.data_out, 8'h11);
        if3.rd = 1'b0;
        step();

        // 5. rd&&wr collision sets sticky err, no access
        if2.rd = 1'b1; if2.wr = 1'b1; if2.addr = 13'h0010; if2.data_in = 8'hFF;
        step();
        chk1("t5_e0_err", if2.err, 1'b1);
        chk1("t5_e0_rdy", if2.rdy, 1'b0);
        step();
        chk1("t5_e1_err", if2.err, 1'b1);
        chk1("t5_e1_busy", if2.busy, 1'b0);
        if2.rd = 1'b0; if2.wr = 1'b0;
        step();
        chk1("t5_sticky_err", if2.err, 1'b1);
        chk1("t5_sticky_rdy", if2.rdy, 1'b0);
        if2.rd = 1'b1;
        step(); step(); step(); step();
        chk1("t5_rd_rdy", if2.rdy, 1'b1);
        chk8("t5_rd_dout", if2.data_out, 8'hA5);
        if2.rd = 1'b0;
        step();
        reset = 1'b1;
        #1;
        chk1("t5_rst_err", if2.err, 1'b0);
        reset = 1'b0;
        step();

        // 6. Reset during WAIT of a write drops the write
        if2.wr = 1'b1; if2.addr = 13'h0010; if2.data_in = 8'h5A;
        step(); step();
        chk1("t6_busy_before", if2.busy, 1'b1);
        #2;
        reset = 1'b1;
        #1;
        chk1("t6_rst_rdy",  if2.rdy,     1'b0);
        chk1("t6_rst_busy", if2.busy,    1'b0);
        chk1("t6_rst_oe",   if2.data_oe, 1'b0);
        chk1("t6_rst_err",  if2.err,     1'b0);
        chk8("t6_rst_dout", if2.data_out, 8'h00);
        if2.wr = 1'b0;
        reset = 1'b0;
        step();
        if2.rd = 1'b1;
        step(); step(); step(); step();
        chk1("t6_rd_rdy", if2.rdy, 1'b1);
        chk8("t6_rd_dout", if2.data_out, 8'hA5);
        if2.rd = 1'b0;
        step();

        $display("[TB] %0d tests run, %0d failed", ntests, nfail);
        $finish;
    end

endmodule
